// File: rtl/counter_pkg.sv
// Shared types for the counter family: FSM state encoding and direction constants.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/prog_modn_counter.sv
// Runtime-programmable modulo-M up/down counter with start/stop, one-shot mode,
// synchronous load and a registered one-cycle terminal-count pulse.
module prog_modn_counter
  import counter_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned N_DEFAULT = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         oneshot,
  input  logic         start,
  input  logic         stop,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         cfg_wr,
  input  logic [W-1:0] mod_val,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] mod_q, mod_d;
  logic [W-1:0] count_q, count_d;
  state_e       state_q, state_d;
  logic         oneshot_q, oneshot_d;
  logic         tc_q, tc_d;
  logic         busy_q, done_q;

  // A modulus of 0 encodes 2^W, so last is formed one bit wider and truncated.
  logic [W:0]   last_ext;
  logic [W-1:0] last;

  assign last_ext = {1'b0, mod_q} - {{W{1'b0}}, 1'b1};
  assign last     = last_ext[W-1:0];

  // Next-count, wrap and state decision, in action priority order.
  always_comb begin
    mod_d     = mod_q;
    count_d   = count_q;
    state_d   = state_q;
    oneshot_d = oneshot_q;
    tc_d      = 1'b0;

    if (cfg_wr) begin
      mod_d   = mod_val;
      count_d = '0;
      state_d = ST_IDLE;
    end else if (load) begin
      count_d = (load_val > last) ? last : load_val;
    end else if (start) begin
      state_d   = ST_RUN;
      count_d   = (up == DIR_UP) ? '0 : last;
      oneshot_d = oneshot;
    end else if (stop && (state_q == ST_RUN)) begin
      state_d = ST_IDLE;
    end else if (en && (state_q == ST_RUN)) begin
      if (up == DIR_UP) begin
        if (count_q == last) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = last;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      if (tc_d && oneshot_q) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mod_q     <= W'(N_DEFAULT);
      count_q   <= '0;
      state_q   <= ST_IDLE;
      oneshot_q <= 1'b0;
      tc_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mod_q     <= mod_d;
      count_q   <= count_d;
      state_q   <= state_d;
      oneshot_q <= oneshot_d;
      tc_q      <= tc_d;
      busy_q    <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
